free_list: RTL

Physical-register free list for the R10K rename stage. It hands out free physical registers to dispatch and takes back the old physical registers released by ROB commit. On a ROB flush it recovers every speculatively allocated register in one cycle by rewinding to a retirement pointer. It sits between the ROB commit/flush outputs and the dispatch/rename logic, and closes the register-lifetime loop the ROB opens.

---
 rtl/free_list.sv | 135 +++++++++++++
 1 files changed

// File: rtl/free_list.sv
// Physical-register free list: speculative head for dispatch, retire_head for 1-cycle flush rewind.
// Latency: grants are combinational from registered state; pointer/count updates at next edge; no bypass of same-cycle frees.
module free_list #(
    parameter int PHYS_REGS      = 128,
    parameter int ARCH_REGS      = 64,
    parameter int DISPATCH_WIDTH = 1,
    parameter int COMMIT_WIDTH   = 1,
    localparam int FL_DEPTH      = PHYS_REGS - ARCH_REGS,
    localparam int PRF_W         = $clog2(PHYS_REGS),
    localparam int FD_W          = $clog2(FL_DEPTH),
    localparam int CNT_W         = $clog2(FL_DEPTH + 1)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [DISPATCH_WIDTH-1:0]             alloc_req_i,
    output logic [DISPATCH_WIDTH-1:0]             alloc_gnt_o,
    output logic [DISPATCH_WIDTH-1:0][PRF_W-1:0]  alloc_prf_o,
    output logic [CNT_W-1:0]                      free_count_o,
    input  logic [COMMIT_WIDTH-1:0]               commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0]               commit_rd_wen_i,
    input  logic [COMMIT_WIDTH-1:0][PRF_W-1:0]    commit_old_prf_i,
    input  logic                                  flush_i,
    output logic                                  overflow_o
);

    localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(FL_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FL_DEPTH);

    logic [PRF_W-1:0] fl_q [FL_DEPTH];
    logic [FD_W-1:0]  head_q, head_d;
    logic [FD_W-1:0]  retire_head_q, retire_head_d;
    logic [FD_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] retire_count_q, retire_count_d;
    logic             overflow_q, overflow_d;

    logic [CNT_W-1:0] n_grant, n_commit, n_retire, n_free, n_fill;
    logic [CNT_W-1:0] outstanding, room;
    logic [COMMIT_WIDTH-1:0] wr_en;
    logic [FD_W-1:0]  wr_ptr [COMMIT_WIDTH];

    function automatic logic [FD_W-1:0] ptr_add(input logic [FD_W-1:0] p, input logic [CNT_W-1:0] n);
        logic [CNT_W:0] s;
        s = (CNT_W + 1)'(p) + (CNT_W + 1)'(n);
        if (s >= DEPTH_X) begin
            s = s - DEPTH_X;
        end
        return s[FD_W-1:0];
    endfunction

    // Grants compact onto consecutive entries starting at head, skipping idle slots.
    always_comb begin
        n_grant     = '0;
        alloc_gnt_o = '0;
        alloc_prf_o = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (alloc_req_i[i] && !flush_i && (n_grant < count_q)) begin
                alloc_gnt_o[i] = 1'b1;
                alloc_prf_o[i] = fl_q[ptr_add(head_q, n_grant)];
                n_grant        = n_grant + CNT_W'(1);
            end
        end
    end

    // retire_head can never pass head, so a commit with nothing outstanding retires nothing;
    // frees beyond what fits between retire_head and capacity are dropped and flagged.
    always_comb begin
        n_commit = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (commit_valid_i[j] && commit_rd_wen_i[j]) begin
                n_commit = n_commit + CNT_W'(1);
            end
        end
        outstanding = retire_count_q - count_q;
        n_retire    = (n_commit < outstanding) ? n_commit : outstanding;
        room        = DEPTH_C - retire_count_q + n_retire;
        n_free      = (n_commit < room) ? n_commit : room;
    end

    always_comb begin
        n_fill = '0;
        wr_en  = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            wr_ptr[j] = ptr_add(tail_q, n_fill);
            if (commit_valid_i[j] && commit_rd_wen_i[j] && (n_fill < n_free)) begin
                wr_en[j] = 1'b1;
                n_fill   = n_fill + CNT_W'(1);
            end
        end
    end

    always_comb begin
        tail_d         = ptr_add(tail_q, n_free);
        retire_head_d  = ptr_add(retire_head_q, n_retire);
        retire_count_d = retire_count_q + n_free - n_retire;
        overflow_d     = overflow_q | (n_commit > n_free);
        if (flush_i) begin
            head_d  = retire_head_d;
            count_d = retire_count_d;
        end else begin
            head_d  = ptr_add(head_q, n_grant);
            count_d = count_q - n_grant + n_free;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= PRF_W'(ARCH_REGS + i);
            end
            head_q         <= '0;
            retire_head_q  <= '0;
            tail_q         <= '0;
            count_q        <= DEPTH_C;
            retire_count_q <= DEPTH_C;
            overflow_q     <= 1'b0;
        end else begin
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (wr_en[j]) begin
                    fl_q[wr_ptr[j]] <= commit_old_prf_i[j];
                end
            end
            head_q         <= head_d;
            retire_head_q  <= retire_head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            retire_count_q <= retire_count_d;
            overflow_q     <= overflow_d;
        end
    end

    assign free_count_o = count_q;
    assign overflow_o   = overflow_q;

endmodule
